// File: rtl/booth_control_param.sv
// Control sequencer for a radix-2 Booth shift-add multiplier datapath.
// Walks LOAD, then EVAL/SHIFT pairs for ITER iterations, then DONE; decodes the Q/A/M/ALU control lines from the state.
module booth_control_param #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH + 2)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic             abort,
  input  logic             c1,
  input  logic             c2,
  output logic             q1,
  output logic             q2,
  output logic             a1,
  output logic             a2,
  output logic             m1,
  output logic             alu1,
  output logic             alu_en,
  output logic             ext_signed,
  output logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_EVAL  = 3'd2,
    S_SHIFT = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           state;
  logic             sgn_q;
  logic [CNT_W-1:0] last_cnt;

  // Unsigned runs one extra iteration to consume the zero-extension bit.
  assign last_cnt = sgn_q ? CNT_W'(WIDTH - 1) : CNT_W'(WIDTH);

  // State, iteration counter and latched operand mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      count <= '0;
      sgn_q <= 1'b1;
    end else if (abort && (state != S_IDLE)) begin
      state <= S_IDLE;
      count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && !abort) begin
            sgn_q <= signed_mode;
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          count <= '0;
          state <= S_EVAL;
        end
        S_EVAL: state <= S_SHIFT;
        S_SHIFT: begin
          count <= count + CNT_W'(1);
          state <= (count == last_cnt) ? S_DONE : S_EVAL;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Control-line decode; everything defaults to hold/0.
  always_comb begin
    q1     = 1'b0;
    q2     = 1'b0;
    a1     = 1'b0;
    a2     = 1'b0;
    m1     = 1'b0;
    alu1   = 1'b0;
    alu_en = 1'b0;
    done   = 1'b0;
    case (state)
      S_LOAD: begin
        q2 = 1'b1;
        a1 = 1'b1;
        a2 = 1'b1;
        m1 = 1'b1;
      end
      S_EVAL: begin
        case ({c1, c2})
          2'b01: begin
            alu_en = 1'b1;
            a2     = 1'b1;
          end
          2'b10: begin
            alu1   = 1'b1;
            alu_en = 1'b1;
            a2     = 1'b1;
          end
          default: ;
        endcase
      end
      S_SHIFT: begin
        q1 = 1'b1;
        a1 = 1'b1;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  assign busy       = (state != S_IDLE);
  assign ext_signed = sgn_q;

endmodule

// File: tb/tb_booth_control_param.sv
// Directed bench for booth_control_param, with a 9-bit behavioural Booth datapath closing the c1/c2 loop.
module tb_booth_control_param;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = $clog2(WIDTH + 2);

  logic clk, rst_n, start, signed_mode, abort, c1, c2;
  logic q1, q2, a1, a2, m1, alu1, alu_en, ext_signed, busy, done;
  logic [CNT_W-1:0] count;

  int total, bad;

  // Datapath model: 9-bit A/Q/M so the unsigned extra iteration fits.
  logic [8:0] dp_a, dp_q, dp_m;
  logic       dp_q1;
  logic [7:0] m_in, q_in;
  logic       force_c, f_c1, f_c2;
  logic signed [17:0] prod;
  logic [8:0] ctl;

  localparam logic [8:0] CTL_IDLE  = 9'b00_00_0_0_0_0_0;
  localparam logic [8:0] CTL_LOAD  = 9'b01_11_1_0_0_1_0;
  localparam logic [8:0] CTL_SHIFT = 9'b10_10_0_0_0_1_0;

  booth_control_param #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode), .abort(abort),
    .c1(c1), .c2(c2), .q1(q1), .q2(q2), .a1(a1), .a2(a2), .m1(m1), .alu1(alu1),
    .alu_en(alu_en), .ext_signed(ext_signed), .count(count), .busy(busy), .done(done)
  );

  assign c1   = force_c ? f_c1 : dp_q[0];
  assign c2   = force_c ? f_c2 : dp_q1;
  assign ctl  = {q1, q2, a1, a2, m1, alu1, alu_en, busy, done};
  assign prod = $signed({dp_a, dp_q}) >>> (ext_signed ? 1 : 0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_a <= '0; dp_q <= '0; dp_m <= '0; dp_q1 <= 1'b0;
    end else begin
      if (m1) dp_m <= ext_signed ? {m_in[7], m_in} : {1'b0, m_in};
      case ({q1, q2})
        2'b01: begin dp_q <= ext_signed ? {q_in[7], q_in} : {1'b0, q_in}; dp_q1 <= 1'b0; end
        2'b10: begin dp_q <= {dp_a[0], dp_q[8:1]}; dp_q1 <= dp_q[0]; end
        2'b11: begin dp_q <= '0; dp_q1 <= 1'b0; end
        default: ;
      endcase
      case ({a1, a2})
        2'b01: if (alu_en) dp_a <= alu1 ? dp_a - dp_m : dp_a + dp_m;
        2'b10: dp_a <= {dp_a[8], dp_a[8:1]};
        2'b11: dp_a <= '0;
        default: ;
      endcase
    end
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    total++; if (ctl !== CTL_IDLE) begin bad++; $display("FAIL reset_ctl got=%b exp=%b", ctl, CTL_IDLE); end
    total++; if (count !== '0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    total++; if (ext_signed !== 1'b1) begin bad++; $display("FAIL reset_ext got=%b exp=1", ext_signed); end
    #2 rst_n = 1'b1;
    tick();
    total++; if (ctl !== CTL_IDLE) begin bad++; $display("FAIL post_reset_idle got=%b exp=%b", ctl, CTL_IDLE); end
  endtask

  task automatic test_signed();
    int cyc;
    force_c = 1'b0; m_in = 8'hFD; q_in = 8'h07; signed_mode = 1'b1; start = 1'b1;
    tick();
    start = 1'b0; signed_mode = 1'b0;
    cyc = 1;
    total++; if (ctl !== CTL_LOAD) begin bad++; $display("FAIL signed_load got=%b exp=%b", ctl, CTL_LOAD); end
    while (done !== 1'b1 && cyc < 60) begin tick(); cyc++; end
    total++; if (cyc !== 18) begin bad++; $display("FAIL signed_done_cycle got=%0d exp=18", cyc); end
    total++; if (count !== 4'd8) begin bad++; $display("FAIL signed_count got=%0d exp=8", count); end
    total++; if (ext_signed !== 1'b1) begin bad++; $display("FAIL signed_ext got=%b exp=1", ext_signed); end
    total++; if (prod[15:0] !== 16'hFFEB) begin bad++; $display("FAIL signed_product got=%h exp=ffeb", prod[15:0]); end
    tick();
    total++; if (ctl !== CTL_IDLE) begin bad++; $display("FAIL signed_idle_after got=%b exp=%b", ctl, CTL_IDLE); end
  endtask

  task automatic test_unsigned();
    int cyc;
    m_in = 8'd200; q_in = 8'd250; signed_mode = 1'b0; start = 1'b1;
    tick();
    start = 1'b0; signed_mode = 1'b1;
    cyc = 1;
    while (done !== 1'b1 && cyc < 60) begin tick(); cyc++; end
    total++; if (cyc !== 20) begin bad++; $display("FAIL unsigned_done_cycle got=%0d exp=20", cyc); end
    total++; if (count !== 4'd9) begin bad++; $display("FAIL unsigned_count got=%0d exp=9", count); end
    total++; if (ext_signed !== 1'b0) begin bad++; $display("FAIL unsigned_ext got=%b exp=0", ext_signed); end
    total++; if (prod !== 18'sd50000) begin bad++; $display("FAIL unsigned_product got=%0d exp=50000", prod); end
    tick();
  endtask

  task automatic test_eval_decode();
    logic [3:0] exp_dec [4];
    logic [1:0] cc;
    exp_dec[0] = 4'b0000; exp_dec[1] = 4'b1001; exp_dec[2] = 4'b1101; exp_dec[3] = 4'b0000;
    force_c = 1'b1; f_c1 = 1'b0; f_c2 = 1'b0; signed_mode = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      cc = 2'(i);
      f_c1 = cc[1]; f_c2 = cc[0];
      #1;
      total++;
      if ({alu_en, alu1, a1, a2} !== exp_dec[i])
        begin bad++; $display("FAIL eval_decode_%0d got=%b exp=%b", i, {alu_en, alu1, a1, a2}, exp_dec[i]); end
    end
    total++; if ({q1, q2, m1} !== 3'b000) begin bad++; $display("FAIL eval_qm got=%b exp=000", {q1, q2, m1}); end
    abort = 1'b1;
    tick();
    abort = 1'b0; force_c = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL eval_abort_busy got=%b exp=0", busy); end
  endtask

  task automatic test_abort();
    logic saw_done;
    m_in = 8'h05; q_in = 8'h03; signed_mode = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    abort = 1'b1;
    #1;
    total++; if (ctl !== CTL_SHIFT) begin bad++; $display("FAIL abort_cycle_ctl got=%b exp=%b", ctl, CTL_SHIFT); end
    total++; if (count !== 4'd2) begin bad++; $display("FAIL abort_cycle_count got=%0d exp=2", count); end
    tick();
    abort = 1'b0;
    total++; if (ctl !== CTL_IDLE) begin bad++; $display("FAIL abort_idle got=%b exp=%b", ctl, CTL_IDLE); end
    total++; if (count !== '0) begin bad++; $display("FAIL abort_count got=%0d exp=0", count); end
    saw_done = 1'b0;
    repeat (25) begin tick(); if (done === 1'b1) saw_done = 1'b1; end
    total++; if (saw_done !== 1'b0) begin bad++; $display("FAIL abort_no_done got=%b exp=0", saw_done); end
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_abort_blocks_start got=%b exp=0", busy); end
  endtask

  task automatic test_back_to_back();
    int ndone;
    m_in = 8'h11; q_in = 8'h22; signed_mode = 1'b1; start = 1'b1;
    tick();
    ndone = 0;
    for (int cyc = 1; cyc <= 18; cyc++) begin
      if (done === 1'b1) ndone++;
      if (cyc < 18) tick();
    end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL b2b_done_c18 got=%b exp=1", done); end
    tick();
    if (done === 1'b1) ndone++;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_idle_c19 got=%b exp=0", busy); end
    total++; if (ndone !== 1) begin bad++; $display("FAIL b2b_done_pulses got=%0d exp=1", ndone); end
    tick();
    total++; if (ctl !== CTL_LOAD) begin bad++; $display("FAIL b2b_restart_c20 got=%b exp=%b", ctl, CTL_LOAD); end
    start = 1'b0; abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic test_reset_mid();
    m_in = 8'h09; q_in = 8'h07; signed_mode = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    total++; if ({alu_en, a1, a2} !== 3'b101) begin bad++; $display("FAIL rmid_eval got=%b exp=101", {alu_en, a1, a2}); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (ctl !== CTL_IDLE) begin bad++; $display("FAIL rmid_ctl got=%b exp=%b", ctl, CTL_IDLE); end
    total++; if (ext_signed !== 1'b1) begin bad++; $display("FAIL rmid_ext got=%b exp=1", ext_signed); end
    #2 rst_n = 1'b1;
    repeat (3) tick();
    total++; if (ctl !== CTL_IDLE) begin bad++; $display("FAIL rmid_stays_idle got=%b exp=%b", ctl, CTL_IDLE); end
    total++; if (count !== '0) begin bad++; $display("FAIL rmid_count got=%0d exp=0", count); end
  endtask

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0; start = 1'b0; signed_mode = 1'b0; abort = 1'b0;
    force_c = 1'b0; f_c1 = 1'b0; f_c2 = 1'b0; m_in = '0; q_in = '0;
    test_reset();
    test_signed();
    test_unsigned();
    test_eval_decode();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/booth_control_param.md
Name: booth_control_param

Overview:
- Parameterised controller for the radix-2 Booth shift-add multiplier datapath (Q, A and M registers, add/sub ALU).
- Sequences load, evaluate and shift for a configurable operand width.
- Supports signed and unsigned operands, a start/busy/done handshake, an iteration counter and a synchronous abort.
- Sits between the top-level lab wrapper and the multiplier datapath; drives only control lines.

Parameters:
WIDTH, 8, operand width in bits; legal range 2..32.
CNT_W, $clog2(WIDTH+2), width of the iteration counter.

Ports:
clk  input  1  system clock, rising-edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request a multiply; sampled only in IDLE.
signed_mode  input  1  1 = signed (two's-complement) operands, 0 = unsigned; latched on accepted start.
abort  input  1  synchronous cancel; returns to IDLE.
c1  input  1  Q0, the multiplier LSB from the datapath.
c2  input  1  Q-1, the Booth extension bit from the datapath.
q1,q2  output  1,1  Q register control code.
a1,a2  output  1,1  A register control code.
m1  output  1  M register parallel load.
alu1  output  1  ALU op: 0 = add M, 1 = subtract M.
alu_en  output  1  A loads the ALU result this cycle.
ext_signed  output  1  latched signed_mode; datapath uses it to sign- or zero-extend operands.
count  output  CNT_W  completed shift iterations.
busy  output  1  high in every state except IDLE.
done  output  1  one-cycle completion pulse.

Behaviour:
- Register codes {x1,x2}:
  - 00 = hold
  - 01 = parallel load (Q load also clears Q-1)
  - 10 = arithmetic shift right (A LSB into Q MSB, Q0 into Q-1)
  - 11 = clear
- Outputs are decoded combinationally from the state register (plus c1,c2 in EVAL).
- Default for all outputs is hold/0.
- Reset (rst_n low, asynchronous): state=IDLE, count=0, latched signed=1. All control outputs are 0, busy=0, done=0.
- ITER = WIDTH when signed, WIDTH+1 when unsigned (the extra iteration consumes the zero extension bit). ITER is fixed by the latched mode.
- IDLE:
  - Outputs hold.
  - start=1 -> latch signed_mode, go to LOAD.
  - start=0 -> stay in IDLE.
- LOAD (one cycle):
  - q=01, a=11, m1=1, count <- 0.
  - Next state: EVAL.
- EVAL (one cycle), decode {c1,c2}:
  - 01 -> alu1=0, alu_en=1, a=01.
  - 10 -> alu1=1, alu_en=1, a=01.
  - 00 or 11 -> alu_en=0, a=00, alu1=0.
  - q=00, m1=0.
  - Next state: SHIFT.
- SHIFT (one cycle):
  - q=10, a=10, count <- count+1.
  - If count == ITER-1 (before increment) -> DONE, else -> EVAL.
- DONE (one cycle):
  - done=1, busy=1, outputs otherwise hold.
  - Next state: IDLE.
  - start asserted during DONE is ignored; it must be re-presented in IDLE.
- Latency: start sampled at edge 0 -> LOAD in cycle 1, DONE in cycle 2+2*ITER, busy low again in cycle 3+2*ITER.
  - Signed WIDTH=8: done in cycle 18.
  - Unsigned WIDTH=8: done in cycle 20.
- start while busy: ignored; signed_mode changes while busy have no effect.
- abort=1 in any non-IDLE state:
  - Next edge -> IDLE, count <- 0, no done pulse.
  - Control outputs in the abort cycle still follow the current state.
  - abort has priority over every other transition.
  - abort in IDLE has no effect, and also blocks a simultaneous start.
- Reset mid-operation: immediate return to the reset values; no done pulse.
- count never exceeds ITER; it holds its final value through DONE and is cleared by the next LOAD.

Test Plan:
- Signed, WIDTH=8, M=-3 (0xFD), Q=7 -> done in cycle 18, count=8, {A,Q} = 0xFFEB (-21).
- Unsigned, WIDTH=8, M=200, Q=250 -> 9 iterations, done in cycle 20, product 50000 (0xC350).
- EVAL decode sweep: force {c1,c2} through 00, 01, 10, 11 -> alu_en/alu1/a equal 0/0/00, 1/0/01, 1/1/01, 0/0/00 respectively.
- Hold start high for the whole operation plus a pulse in DONE -> exactly one operation; a second run starts only after one IDLE cycle with start re-sampled.
- abort asserted in the 3rd SHIFT -> IDLE on the next edge, done never asserts, count=0, busy=0.
- rst_n low mid-EVAL (asynchronous, between edges) -> outputs zero immediately; after release with start=0 the block stays in IDLE with all outputs hold.
